irrigation_scheduler: RTL and testbench
=======================================

IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 SHALL have parameter SPRINKLER_TICKS, default 9, the sprinkler run length in ticks (legal range 1..9).
REQ-002 SHALL have parameter DRIPPER_TICKS, default 6, the dripper run length in ticks (legal range 1..9).
REQ-003 SHALL have parameter SOAK_TICKS, default 3, the post-irrigation soak length in ticks (legal range 1..9).
REQ-004 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port tick  input  1  one-cycle time-base enable from the clock divider chain.
REQ-007 SHALL have port irrigation_request  input  1  1 = prerequisites met (soil dry, no conflict, water present).
REQ-008 SHALL have port splinker_mode_on  input  1  1 = sprinkler mode selected, 0 = dripper mode.
REQ-009 SHALL have port water_available  input  1  1 = tank level above the low sensor.
REQ-010 SHALL have port tank_full  input  1  1 = high level sensor active.
REQ-011 SHALL have port conflicting_values  input  1  1 = inconsistent level sensors.
REQ-012 SHALL have port splinker_bomb  output  1  sprinkler pump drive.
REQ-013 SHALL have port dripper_valvule  output  1  dripper valve drive.
REQ-014 SHALL have port water_supply_valvule  output  1  tank inlet valve drive.
REQ-015 SHALL have port countdown  output  4  BCD remaining ticks of current phase (0..9).
REQ-016 SHALL have port cycle_count  output  3  completed irrigation cycles, modulo 8.
REQ-017 SHALL have port state  output  3  current FSM state code.
REQ-018 SHALL have port fault  output  1  1 while in FAULT.

Function
REQ-019 SHALL implement a Moore FSM: IDLE=000, IRRIGATE=001, SOAK=010, REFILL=011, FAULT=100; all outputs registered.
REQ-020 SHALL evaluate transitions every clock edge; countdown decrements only on edges where tick=1.
REQ-021 SHALL apply exit priority in every state: conflicting_values, then water_available=0, then tick/timer events.
REQ-022 IDLE: all valves 0, countdown 0; conflict -> FAULT; else water_available=0 -> REFILL; else irrigation_request=1 -> IRRIGATE.
REQ-023 On IDLE->IRRIGATE SHALL latch splinker_mode_on and load countdown with SPRINKLER_TICKS (latched 1) or DRIPPER_TICKS (latched 0).
REQ-024 IRRIGATE: splinker_bomb = latched mode, dripper_valvule = not latched mode; changes of splinker_mode_on and irrigation_request ignored until exit.
REQ-025 IRRIGATE: on tick with countdown=1 -> SOAK, countdown loaded with SOAK_TICKS, cycle_count incremented (7 wraps to 0); on tick with countdown>1 -> decrement.
REQ-026 IRRIGATE abort: conflict -> FAULT, water_available=0 -> REFILL; both with cycle_count unchanged and countdown cleared to 0.
REQ-027 SOAK: all valves 0; on tick with countdown=1 -> IDLE with countdown 0; otherwise decrement on tick; conflict -> FAULT.
REQ-028 REFILL: water_supply_valvule=1, other valves 0, countdown 0; tank_full=1 -> IDLE; conflict -> FAULT.
REQ-029 FAULT: all valves 0, fault=1, countdown 0; exit to IDLE only after conflicting_values=0 sampled on two consecutive tick edges; any conflict=1 clears that qualifier.
REQ-030 Latency: input condition sampled on edge N SHALL be visible on outputs immediately after edge N (one cycle).
REQ-031 splinker_bomb, dripper_valvule and water_supply_valvule SHALL never be 1 in the same cycle as each other or as fault.
REQ-032 A conflict coinciding with the terminal tick in IRRIGATE SHALL go to FAULT without incrementing cycle_count.

Reset
REQ-033 reset_n=0 on a clock edge SHALL force IDLE, all valves 0, fault 0, countdown 0, cycle_count 0, mode latch 0, FAULT qualifier 0, including mid-IRRIGATE.
REQ-034 reset_n SHALL take priority over every other input; tick ignored during reset.

Verification
REQ-035 Request=1, mode=1, water ok, tick every 4 clocks -> splinker_bomb high for exactly 9 ticks, countdown 9..1, SOAK 3 ticks, cycle_count 0->1, return to IDLE.
REQ-036 Mode=0, then toggle splinker_mode_on mid-run -> dripper_valvule only, 6 ticks, no switch to sprinkler.
REQ-037 conflicting_values=1 at countdown=5 in IRRIGATE -> next cycle FAULT, valves 0, fault=1; conflict cleared -> IDLE after 2 ticks; cycle_count unchanged.
REQ-038 water_available=0 in IRRIGATE -> REFILL, water_supply_valvule=1 until tank_full=1, then IDLE.
REQ-039 Eight complete cycles -> cycle_count wraps 7->0; conflict coincident with terminal tick -> FAULT, no increment.
REQ-040 reset_n=0 for one edge mid-IRRIGATE -> all outputs 0, state 000 next cycle.

Source files
------------

// File: rtl/irrigation_scheduler.sv
// -----------------------------------------------------------------------------
// irrigation_scheduler
//
// Purpose:
//   Moore-style controller for a small irrigation rig. It runs a sprinkler
//   or dripper phase, then a soak phase, and counts completed cycles. It also
//   handles tank refill and a latched fault state. All timers advance only
//   on the one-cycle 'tick' enable.
//
// Parameters:
//   SPRINKLER_TICKS  sprinkler run length in ticks (1..9)
//   DRIPPER_TICKS    dripper run length in ticks   (1..9)
//   SOAK_TICKS       soak length in ticks          (1..9)
//
// Ports:
//   clock                 system clock, rising-edge
//   reset_n               synchronous active-low reset
//   tick                  one-cycle time-base enable
//   irrigation_request    prerequisites met, start a cycle from IDLE
//   splinker_mode_on      1 = sprinkler, 0 = dripper (latched at start)
//   water_available       tank above low sensor
//   tank_full             high level sensor active
//   conflicting_values    inconsistent level sensors
//   splinker_bomb         sprinkler pump drive
//   dripper_valvule       dripper valve drive
//   water_supply_valvule  tank inlet valve drive
//   countdown             remaining ticks of current phase (BCD 0..9)
//   cycle_count           completed irrigation cycles, modulo 8
//   state                 current state code
//   fault                 1 while in FAULT
// -----------------------------------------------------------------------------
module irrigation_scheduler #(
    parameter int unsigned SPRINKLER_TICKS = 9,
    parameter int unsigned DRIPPER_TICKS   = 6,
    parameter int unsigned SOAK_TICKS      = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       irrigation_request,
    input  logic       splinker_mode_on,
    input  logic       water_available,
    input  logic       tank_full,
    input  logic       conflicting_values,
    output logic       splinker_bomb,
    output logic       dripper_valvule,
    output logic       water_supply_valvule,
    output logic [3:0] countdown,
    output logic [2:0] cycle_count,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_IRRIGATE = 3'b001,
        ST_SOAK     = 3'b010,
        ST_REFILL   = 3'b011,
        ST_FAULT    = 3'b100
    } state_t;

    // Run lengths are at most 9, so plain binary equals BCD here.
    localparam logic [3:0] SPRINKLER_LOAD = 4'(SPRINKLER_TICKS);
    localparam logic [3:0] DRIPPER_LOAD   = 4'(DRIPPER_TICKS);
    localparam logic [3:0] SOAK_LOAD      = 4'(SOAK_TICKS);

    state_t     state_reg, state_next;
    logic [3:0] countdown_reg, countdown_next;
    logic [2:0] cycle_reg, cycle_next;
    logic       mode_reg, mode_next;
    // Set after the first conflict-free tick in FAULT; a second one exits.
    logic       qual_reg, qual_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            countdown_reg <= 4'd0;
            cycle_reg     <= 3'd0;
            mode_reg      <= 1'b0;
            qual_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            countdown_reg <= countdown_next;
            cycle_reg     <= cycle_next;
            mode_reg      <= mode_next;
            qual_reg      <= qual_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority in each state: conflict, then loss of
    // water, then tick/timer events.
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        countdown_next = countdown_reg;
        cycle_next     = cycle_reg;
        mode_next      = mode_reg;
        qual_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                countdown_next = 4'd0;
                if (conflicting_values) begin
                    state_next = ST_FAULT;
                end else if (!water_available) begin
                    state_next = ST_REFILL;
                end else if (irrigation_request) begin
                    state_next     = ST_IRRIGATE;
                    mode_next      = splinker_mode_on;
                    countdown_next = splinker_mode_on ? SPRINKLER_LOAD : DRIPPER_LOAD;
                end
            end

            ST_IRRIGATE: begin
                if (conflicting_values) begin
                    // Abort beats the terminal tick, so no cycle is counted.
                    state_next     = ST_FAULT;
                    countdown_next = 4'd0;
                end else if (!water_available) begin
                    state_next     = ST_REFILL;
                    countdown_next = 4'd0;
                end else if (tick) begin
                    if (countdown_reg <= 4'd1) begin
                        state_next     = ST_SOAK;
                        countdown_next = SOAK_LOAD;
                        cycle_next     = cycle_reg + 3'd1;
                    end else begin
                        countdown_next = countdown_reg - 4'd1;
                    end
                end
            end

            ST_SOAK: begin
                if (conflicting_values) begin
                    state_next     = ST_FAULT;
                    countdown_next = 4'd0;
                end else if (!water_available) begin
                    state_next     = ST_REFILL;
                    countdown_next = 4'd0;
                end else if (tick) begin
                    if (countdown_reg <= 4'd1) begin
                        state_next     = ST_IDLE;
                        countdown_next = 4'd0;
                    end else begin
                        countdown_next = countdown_reg - 4'd1;
                    end
                end
            end

            ST_REFILL: begin
                countdown_next = 4'd0;
                if (conflicting_values) begin
                    state_next = ST_FAULT;
                end else if (tank_full) begin
                    state_next = ST_IDLE;
                end
            end

            ST_FAULT: begin
                countdown_next = 4'd0;
                if (conflicting_values) begin
                    qual_next = 1'b0;
                end else if (tick) begin
                    if (qual_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        qual_next = 1'b1;
                    end
                end else begin
                    qual_next = qual_reg;
                end
            end

            default: begin
                state_next     = ST_IDLE;
                countdown_next = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode, purely from registered state (Moore)
    // ------------------------------------------------------------------
    always_comb begin
        splinker_bomb        = 1'b0;
        dripper_valvule      = 1'b0;
        water_supply_valvule = 1'b0;
        fault                = 1'b0;
        countdown            = countdown_reg;
        cycle_count          = cycle_reg;
        state                = state_reg;
        case (state_reg)
            ST_IRRIGATE: begin
                splinker_bomb   = mode_reg;
                dripper_valvule = ~mode_reg;
            end
            ST_REFILL: water_supply_valvule = 1'b1;
            ST_FAULT:  fault                = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_irrigation_scheduler.sv
`timescale 1ns/1ps
module tb_irrigation_scheduler;

    localparam int SPR_T  = 9;
    localparam int DRP_T  = 6;
    localparam int SOAK_T = 3;

    localparam int P_IDLE = 0, P_IRR = 1, P_SOAK = 2, P_REFILL = 3, P_FAULT = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       irrigation_request = 1'b0;
    logic       splinker_mode_on = 1'b0;
    logic       water_available = 1'b1;
    logic       tank_full = 1'b0;
    logic       conflicting_values = 1'b0;
    logic       splinker_bomb, dripper_valvule, water_supply_valvule, fault;
    logic [3:0] countdown;
    logic [2:0] cycle_count, state;

    irrigation_scheduler #(
        .SPRINKLER_TICKS(SPR_T),
        .DRIPPER_TICKS  (DRP_T),
        .SOAK_TICKS     (SOAK_T)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .tick                (tick),
        .irrigation_request  (irrigation_request),
        .splinker_mode_on    (splinker_mode_on),
        .water_available     (water_available),
        .tank_full           (tank_full),
        .conflicting_values  (conflicting_values),
        .splinker_bomb       (splinker_bomb),
        .dripper_valvule     (dripper_valvule),
        .water_supply_valvule(water_supply_valvule),
        .countdown           (countdown),
        .cycle_count         (cycle_count),
        .state               (state),
        .fault               (fault)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference: phase, ticks left in phase, total cycles ever
    // completed, latched mode, conflict-free ticks seen in FAULT.
    int m_phase = P_IDLE;
    int m_left = 0;
    int m_cycles = 0;
    bit m_mode = 0;
    int m_quiet = 0;

    logic [13:0] exp_q[$];

    task automatic model_step();
        if (!reset_n) begin
            m_phase = P_IDLE; m_left = 0; m_cycles = 0; m_mode = 0; m_quiet = 0;
            return;
        end
        if (m_phase != P_FAULT) m_quiet = 0;
        case (m_phase)
            P_IDLE: begin
                if (conflicting_values) m_phase = P_FAULT;
                else if (!water_available) m_phase = P_REFILL;
                else if (irrigation_request) begin
                    m_phase = P_IRR;
                    m_mode  = splinker_mode_on;
                    m_left  = splinker_mode_on ? SPR_T : DRP_T;
                end
            end
            P_IRR, P_SOAK: begin
                if (conflicting_values) begin
                    m_phase = P_FAULT; m_left = 0;
                end else if (!water_available) begin
                    m_phase = P_REFILL; m_left = 0;
                end else if (tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_phase == P_IRR) begin
                            m_phase = P_SOAK; m_left = SOAK_T; m_cycles++;
                        end else begin
                            m_phase = P_IDLE;
                        end
                    end
                end
            end
            P_REFILL: begin
                if (conflicting_values) m_phase = P_FAULT;
                else if (tank_full) m_phase = P_IDLE;
            end
            default: begin
                if (conflicting_values) m_quiet = 0;
                else if (tick) begin
                    m_quiet++;
                    if (m_quiet == 2) begin
                        m_phase = P_IDLE; m_quiet = 0;
                    end
                end
            end
        endcase
    endtask

    function automatic logic [13:0] model_outputs();
        logic sb, dv, ws, f;
        logic [3:0] cd;
        logic [2:0] cc, st;
        sb = (m_phase == P_IRR) && m_mode;
        dv = (m_phase == P_IRR) && !m_mode;
        ws = (m_phase == P_REFILL);
        f  = (m_phase == P_FAULT);
        cd = 4'(m_left);
        cc = 3'(m_cycles % 8);
        st = 3'(m_phase);
        return {sb, dv, ws, cd, cc, st, f};
    endfunction

    // One clock: inputs already stable, reference steps on the same edge.
    task automatic step(input logic t);
        tick = t;
        @(posedge clock);
        model_step();
        exp_q.push_back(model_outputs());
        #1;
        tick = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0); step(1'b0); step(1'b0); step(1'b1);
        end
    endtask

    task automatic check(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set.
    initial begin
        logic [13:0] act, exp_v;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act = {splinker_bomb, dripper_valvule, water_supply_valvule,
                       countdown, cycle_count, state, fault};
                n_checks++;
                if (act !== exp_v) begin
                    n_errors++;
                    $display("FAIL outputs @%0t: got sb%b dv%b ws%b cd%0d cc%0d st%0d f%b, expected sb%b dv%b ws%b cd%0d cc%0d st%0d f%b",
                             $time, act[13], act[12], act[11], act[10:7], act[6:4], act[3:1], act[0],
                             exp_v[13], exp_v[12], exp_v[11], exp_v[10:7], exp_v[6:4], exp_v[3:1], exp_v[0]);
                end
                n_checks++;
                if ($countones({splinker_bomb, dripper_valvule, water_supply_valvule, fault}) > 1) begin
                    n_errors++;
                    $display("FAIL exclusive @%0t: got drives %b, expected at most one set", $time,
                             {splinker_bomb, dripper_valvule, water_supply_valvule, fault});
                end
            end
        end
    end

    initial begin
        int guard;
        // Reset
        reset_n = 1'b0;
        step(1'b1); step(1'b0);
        reset_n = 1'b1;
        #2;
        check("reset_state", int'(state), 0);
        check("reset_count", int'(cycle_count), 0);
        $display("scenario reset done");

        // Sprinkler cycle with tick every 4 clocks
        splinker_mode_on = 1'b1; irrigation_request = 1'b1;
        step(1'b0);
        irrigation_request = 1'b0;
        #2 check("spr_start_cd", int'(countdown), SPR_T);
        run_ticks(SPR_T);
        #2 check("spr_soak_state", int'(state), P_SOAK);
        run_ticks(SOAK_T);
        step(1'b0);
        #2 check("spr_done_count", int'(cycle_count), 1);
        check("spr_done_state", int'(state), P_IDLE);
        $display("scenario sprinkler cycle done");

        // Dripper cycle, mode toggled mid-run
        splinker_mode_on = 1'b0; irrigation_request = 1'b1;
        step(1'b0);
        irrigation_request = 1'b0;
        run_ticks(3);
        splinker_mode_on = 1'b1;
        step(1'b0);
        #2 check("drip_toggle_sb", int'(splinker_bomb), 0);
        check("drip_toggle_dv", int'(dripper_valvule), 1);
        run_ticks(DRP_T - 3);
        #2 check("drip_soak_state", int'(state), P_SOAK);
        run_ticks(SOAK_T);
        $display("scenario dripper toggle done");

        // Conflict at countdown 5, then recovery after two clean ticks
        splinker_mode_on = 1'b1; irrigation_request = 1'b1;
        step(1'b0);
        irrigation_request = 1'b0;
        guard = 0;
        while (m_left != 5 && guard < 20) begin run_ticks(1); guard++; end
        conflicting_values = 1'b1;
        step(1'b0);
        conflicting_values = 1'b0;
        #2 check("conf_fault", int'(fault), 1);
        check("conf_count", int'(cycle_count), 2);
        run_ticks(1);
        conflicting_values = 1'b1; step(1'b0); conflicting_values = 1'b0;
        run_ticks(1);
        #2 check("conf_requalify", int'(state), P_FAULT);
        run_ticks(1);
        #2 check("conf_exit", int'(state), P_IDLE);
        $display("scenario conflict done");

        // Water loss during irrigation -> refill until tank full
        splinker_mode_on = 1'b0; irrigation_request = 1'b1;
        step(1'b0);
        irrigation_request = 1'b0;
        run_ticks(2);
        water_available = 1'b0;
        step(1'b0); step(1'b1); step(1'b0);
        #2 check("refill_valve", int'(water_supply_valvule), 1);
        water_available = 1'b1; tank_full = 1'b1;
        step(1'b0);
        tank_full = 1'b0;
        #2 check("refill_exit", int'(state), P_IDLE);
        $display("scenario refill done");

        // Eight cycles from reset wrap the counter, then terminal-tick conflict
        reset_n = 1'b0; step(1'b0); reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            splinker_mode_on = 1'($urandom_range(0, 1));
            irrigation_request = 1'b1;
            step(1'b0);
            irrigation_request = 1'b0;
            run_ticks(m_left + SOAK_T);
            if (c == 6) #2 check("wrap_seven", int'(cycle_count), 7);
        end
        #2 check("wrap_zero", int'(cycle_count), 0);
        irrigation_request = 1'b1; splinker_mode_on = 1'b0;
        step(1'b0);
        irrigation_request = 1'b0;
        guard = 0;
        while (m_left > 1 && guard < 20) begin run_ticks(1); guard++; end
        step(1'b0); step(1'b0); step(1'b0);
        conflicting_values = 1'b1;
        step(1'b1);
        conflicting_values = 1'b0;
        #2 check("terminal_conf_state", int'(state), P_FAULT);
        check("terminal_conf_count", int'(cycle_count), 0);
        run_ticks(2);
        $display("scenario wrap and terminal conflict done");

        // Reset for one edge mid-irrigation
        splinker_mode_on = 1'b1; irrigation_request = 1'b1;
        step(1'b0);
        irrigation_request = 1'b0;
        run_ticks(2);
        reset_n = 1'b0;
        step(1'b1);
        reset_n = 1'b1;
        #2 check("midrun_reset_state", int'(state), 0);
        check("midrun_reset_sb", int'(splinker_bomb), 0);
        check("midrun_reset_cd", int'(countdown), 0);
        $display("scenario mid-run reset done");

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset_n            = ($urandom_range(0, 299) != 0);
            conflicting_values = ($urandom_range(0, 49) == 0);
            water_available    = ($urandom_range(0, 39) != 0);
            tank_full          = ($urandom_range(0, 3) == 0);
            irrigation_request = 1'($urandom_range(0, 1));
            splinker_mode_on   = 1'($urandom_range(0, 1));
            step($urandom_range(0, 2) == 0);
        end
        $display("scenario random traffic done");

        // Drain the scoreboard
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin @(negedge clock); guard++; end
        @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
